// File: rtl/dsp_seq_controller.sv
// dsp_seq_controller: instruction sequencer for the DSP slice and the BRAM0/BRAM1 ports.
// Instructions arrive over valid/ready. Each one runs rpt+1 elements of EXEC_LAT
// cycles each. Addresses can optionally step by one per element.
module dsp_seq_controller #(
    parameter int ADDR_WIDTH    = 5,
    parameter int ALUMODE_WIDTH = 4,
    parameter int OPMODE_WIDTH  = 7,
    parameter int INMODE_WIDTH  = 5,
    parameter int RPT_WIDTH     = 4,
    parameter int EXEC_LAT      = 3,
    parameter int I_WIDTH       = RPT_WIDTH + 2 + ALUMODE_WIDTH + OPMODE_WIDTH
                                  + INMODE_WIDTH + 3 * ADDR_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [I_WIDTH-1:0]       instr_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     bram1_web_o,
    output logic                     bram1_reb_o,
    output logic                     bram0_reb_o,
    output logic [ALUMODE_WIDTH-1:0] alumode_o,
    output logic [OPMODE_WIDTH-1:0]  opmode_o,
    output logic [INMODE_WIDTH-1:0]  inmode_o,
    output logic [ADDR_WIDTH-1:0]    bram1_w_addr_o,
    output logic [ADDR_WIDTH-1:0]    bram1_r_addr_o,
    output logic [ADDR_WIDTH-1:0]    bram0_r_addr_o
);

    // Instruction field positions, LSB upwards: r0, r1, w, inmode, opmode, alumode, exec, inc, rpt
    localparam int R0_LSB   = 0;
    localparam int R1_LSB   = ADDR_WIDTH;
    localparam int W_LSB    = 2 * ADDR_WIDTH;
    localparam int IN_LSB   = 3 * ADDR_WIDTH;
    localparam int OP_LSB   = IN_LSB + INMODE_WIDTH;
    localparam int ALU_LSB  = OP_LSB + OPMODE_WIDTH;
    localparam int EXEC_BIT = ALU_LSB + ALUMODE_WIDTH;
    localparam int INC_BIT  = EXEC_BIT + 1;
    localparam int RPT_LSB  = INC_BIT + 1;

    // The cycle counter keeps at least one bit so that EXEC_LAT=1 still elaborates
    localparam int            CW     = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(EXEC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    state_e                   state_q,   state_d;
    logic [RPT_WIDTH-1:0]     e_q,       e_d;
    logic [CW-1:0]            c_q,       c_d;
    logic [RPT_WIDTH-1:0]     rpt_q,     rpt_d;
    logic                     inc_q,     inc_d;
    logic                     exec_q,    exec_d;
    logic [ALUMODE_WIDTH-1:0] alumode_q, alumode_d;
    logic [OPMODE_WIDTH-1:0]  opmode_q,  opmode_d;
    logic [INMODE_WIDTH-1:0]  inmode_q,  inmode_d;
    logic [ADDR_WIDTH-1:0]    w_addr_q,  w_addr_d;
    logic [ADDR_WIDTH-1:0]    r1_addr_q, r1_addr_d;
    logic [ADDR_WIDTH-1:0]    r0_addr_q, r0_addr_d;

    // State, counters, latched instruction fields and the mode/address outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            c_q       <= '0;
            rpt_q     <= '0;
            inc_q     <= 1'b0;
            exec_q    <= 1'b0;
            alumode_q <= '0;
            opmode_q  <= '0;
            inmode_q  <= '0;
            w_addr_q  <= '0;
            r1_addr_q <= '0;
            r0_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            c_q       <= c_d;
            rpt_q     <= rpt_d;
            inc_q     <= inc_d;
            exec_q    <= exec_d;
            alumode_q <= alumode_d;
            opmode_q  <= opmode_d;
            inmode_q  <= inmode_d;
            w_addr_q  <= w_addr_d;
            r1_addr_q <= r1_addr_d;
            r0_addr_q <= r0_addr_d;
        end
    end

    // Next state: accept in IDLE, walk elements in EXEC, one-cycle DONE back to IDLE
    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        c_d       = c_q;
        rpt_d     = rpt_q;
        inc_d     = inc_q;
        exec_d    = exec_q;
        alumode_d = alumode_q;
        opmode_d  = opmode_q;
        inmode_d  = inmode_q;
        w_addr_d  = w_addr_q;
        r1_addr_d = r1_addr_q;
        r0_addr_d = r0_addr_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    rpt_d     = instr_i[RPT_LSB +: RPT_WIDTH];
                    inc_d     = instr_i[INC_BIT];
                    exec_d    = instr_i[EXEC_BIT];
                    alumode_d = instr_i[ALU_LSB +: ALUMODE_WIDTH];
                    opmode_d  = instr_i[OP_LSB +: OPMODE_WIDTH];
                    inmode_d  = instr_i[IN_LSB +: INMODE_WIDTH];
                    w_addr_d  = instr_i[W_LSB +: ADDR_WIDTH];
                    r1_addr_d = instr_i[R1_LSB +: ADDR_WIDTH];
                    r0_addr_d = instr_i[R0_LSB +: ADDR_WIDTH];
                    e_d       = '0;
                    c_d       = '0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (c_q == C_LAST) begin
                    if (e_q < rpt_q) begin
                        e_d = e_q + 1'b1;
                        c_d = '0;
                        // Stepping the registered address tracks base+e, wrapping naturally
                        if (inc_q) begin
                            w_addr_d  = w_addr_q + 1'b1;
                            r1_addr_d = r1_addr_q + 1'b1;
                            r0_addr_d = r0_addr_q + 1'b1;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and enables decode straight from registered state, so reset forces them low
    assign instr_ready_o  = (state_q == S_IDLE);
    assign busy_o         = (state_q == S_EXEC);
    assign done_o         = (state_q == S_DONE);
    assign bram0_reb_o    = busy_o & exec_q;
    assign bram1_reb_o    = busy_o & exec_q;
    assign bram1_web_o    = busy_o & exec_q & (c_q == C_LAST);
    assign alumode_o      = alumode_q;
    assign opmode_o       = opmode_q;
    assign inmode_o       = inmode_q;
    assign bram1_w_addr_o = w_addr_q;
    assign bram1_r_addr_o = r1_addr_q;
    assign bram0_r_addr_o = r0_addr_q;

endmodule

// File: tb/tb_dsp_seq_controller.sv
// Testbench for dsp_seq_controller: per-instruction expected traces go into a scoreboard
// and are compared cycle by cycle on the falling clock edge.
module tb_dsp_seq_controller;

    localparam int AW  = 5;
    localparam int ALW = 4;
    localparam int OPW = 7;
    localparam int INW = 5;
    localparam int RW  = 4;
    localparam int L   = 3;
    localparam int IW  = RW + 2 + ALW + OPW + INW + 3 * AW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [IW-1:0]  instr;
    logic           valid;
    logic           abort;
    logic           ready, busy, done, web, reb1, reb0;
    logic [ALW-1:0] alu;
    logic [OPW-1:0] op;
    logic [INW-1:0] inm;
    logic [AW-1:0]  waddr, r1addr, r0addr;

    dsp_seq_controller #(
        .ADDR_WIDTH(AW), .ALUMODE_WIDTH(ALW), .OPMODE_WIDTH(OPW),
        .INMODE_WIDTH(INW), .RPT_WIDTH(RW), .EXEC_LAT(L)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(valid),
        .instr_ready_o(ready), .abort_i(abort), .busy_o(busy), .done_o(done),
        .bram1_web_o(web), .bram1_reb_o(reb1), .bram0_reb_o(reb0),
        .alumode_o(alu), .opmode_o(op), .inmode_o(inm),
        .bram1_w_addr_o(waddr), .bram1_r_addr_o(r1addr), .bram0_r_addr_o(r0addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rpt; bit inc; bit ex;
        int alu; int op; int inm; int w; int r1; int r0;
        int exp_done; int exp_webs; int exp_last_w;
    } vec_t;

    typedef struct {
        int cyc;
        logic ready, busy, done, reb, web;
        logic [AW-1:0] w, r1, r0;
        logic [ALW-1:0] alu;
        logic [OPW-1:0] op;
        logic [INW-1:0] inm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[5];
    int checks = 0;
    int errors = 0;
    int web_total = 0;
    int web_base = 0;
    int last_w = 0;
    int last_done_cyc = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, act, expv);
        end
    endtask

    function automatic logic [IW-1:0] pack(input vec_t v);
        return {RW'(v.rpt), v.inc, v.ex, ALW'(v.alu), OPW'(v.op), INW'(v.inm),
                AW'(v.w), AW'(v.r1), AW'(v.r0)};
    endfunction

    task automatic push_trace(input vec_t v, input int t);
        exp_t r;
        int n;
        n = (v.rpt + 1) * L;
        for (int k = 0; k <= n; k++) begin
            int e;
            int c;
            e = (k < n) ? k / L : v.rpt;
            c = k % L;
            r.cyc   = t + 1 + k;
            r.ready = 1'b0;
            r.busy  = (k < n);
            r.done  = (k == n);
            r.reb   = (k < n) && v.ex;
            r.web   = (k < n) && v.ex && (c == L - 1);
            r.w     = AW'(v.w  + (v.inc ? e : 0));
            r.r1    = AW'(v.r1 + (v.inc ? e : 0));
            r.r0    = AW'(v.r0 + (v.inc ? e : 0));
            r.alu   = ALW'(v.alu);
            r.op    = OPW'(v.op);
            r.inm   = INW'(v.inm);
            sb.push_back(r);
        end
    endtask

    task automatic monitor();
        exp_t r;
        if (!rst_n) return;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            r = sb.pop_front();
            chk("ready", ready, r.ready);
            chk("busy", busy, r.busy);
            chk("done", done, r.done);
            chk("reb0", reb0, r.reb);
            chk("reb1", reb1, r.reb);
            chk("web", web, r.web);
            chk("w_addr", waddr, r.w);
            chk("r1_addr", r1addr, r.r1);
            chk("r0_addr", r0addr, r.r0);
            chk("alumode", alu, r.alu);
            chk("opmode", op, r.op);
            chk("inmode", inm, r.inm);
        end else begin
            chk("idle_ready", ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_reb0", reb0, 0);
            chk("idle_reb1", reb1, 0);
            chk("idle_web", web, 0);
        end
        if (web === 1'b1) begin
            web_total++;
            last_w = int'(waddr);
        end
        if (done === 1'b1) last_done_cyc = cyc;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic offer(input vec_t v, output int t);
        int n;
        n = 0;
        instr = pack(v);
        valid = 1'b1;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            t = cyc;
        end else begin
            t = cyc;
            push_trace(v, t);
            web_base = web_total;
        end
        tick();
    endtask

    task automatic wait_done(input vec_t v, input int t);
        int n;
        n = 0;
        while (last_done_cyc <= t && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", (last_done_cyc > t), 1);
        chk("done_lat", last_done_cyc - t, v.exp_done);
        chk("web_count", web_total - web_base, v.exp_webs);
        if (v.exp_webs > 0) chk("last_w", last_w, v.exp_last_w);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_web"}, web, 0);
        chk({tag, "_reb0"}, reb0, 0);
        chk({tag, "_reb1"}, reb1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_alu"}, alu, 0);
        chk({tag, "_op"}, op, 0);
        chk({tag, "_inm"}, inm, 0);
        chk({tag, "_w"}, waddr, 0);
        chk({tag, "_r1"}, r1addr, 0);
        chk({tag, "_r0"}, r0addr, 0);
        chk({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        int t, ta, tb2;
        vec_t va, vr;
        // rpt inc ex alu op inm w r1 r0 | done_offset webs last_w
        tbl[0] = '{0,  1'b0, 1'b1, 'h3, 'h35, 'h11, 3,  4,  5,  4,  1,  3};
        tbl[1] = '{3,  1'b1, 1'b1, 'h5, 'h22, 'h05, 30, 30, 30, 13, 4,  1};
        tbl[2] = '{2,  1'b0, 1'b0, 'hA, 'h7F, 'h1F, 7,  8,  9,  10, 0,  0};
        tbl[3] = '{1,  1'b1, 1'b1, 'h1, 'h01, 'h02, 31, 0,  15, 7,  2,  0};
        tbl[4] = '{15, 1'b1, 1'b1, 'hF, 'h40, 'h10, 20, 1,  2,  49, 16, 3};
        va     = '{5,  1'b1, 1'b1, 'h2, 'h11, 'h04, 10, 11, 12, 19, 6,  15};
        vr     = '{3,  1'b1, 1'b1, 'h6, 'h0C, 'h03, 10, 20, 25, 13, 4,  13};

        rst_n = 1'b0;
        valid = 1'b0;
        abort = 1'b0;
        instr = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            offer(tbl[i], t);
            valid = 1'b0;
            wait_done(tbl[i], t);
        end

        // Held-high valid with two queued instructions
        offer(tbl[0], ta);
        offer(tbl[3], tb2);
        valid = 1'b0;
        chk("b2b_accept", tb2 - ta, 5);
        wait_done(tbl[3], tb2);

        // Abort at element 2, c=1
        offer(va, t);
        valid = 1'b0;
        while (cyc < t + 8) tick();
        abort = 1'b1;
        #1;
        while (sb.size() > 0 && sb[$].cyc > t + 8) void'(sb.pop_back());
        tick();
        abort = 1'b0;
        repeat (4) tick();
        chk("abort_webs", web_total - web_base, 2);
        chk("abort_no_done", (last_done_cyc > t), 0);
        chk("abort_ready", ready, 1);

        // Abort held in IDLE at acceptance and in DONE is ignored
        abort = 1'b1;
        offer(tbl[0], t);
        valid = 1'b0;
        abort = 1'b0;
        while (cyc < t + 4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(tbl[0], t);

        // Asynchronous reset in the middle of element 1
        offer(vr, t);
        valid = 1'b0;
        while (cyc < t + 5) tick();
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_zero("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        chk("midrst_webs", web_total - web_base, 1);
        tick();
        offer(tbl[3], t);
        valid = 1'b0;
        wait_done(tbl[3], t);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_seq_controller.md
Name: dsp_seq_controller

Overview:
Parametrised instruction sequencer that drives the DSP slice mode buses and the BRAM0/BRAM1 enables and addresses. It accepts instructions over a valid/ready handshake, so no start/valid level protocol is used. Each instruction may repeat over a vector of elements, with optional auto-increment of all three addresses, and runs on a configurable execute latency. It sits between the instruction source (host FSM or instruction ROM) and the DSP/BRAM datapath.

Parameters:
ADDR_WIDTH, 5, width of every BRAM address field and port
ALUMODE_WIDTH, 4, DSP ALUMODE width
OPMODE_WIDTH, 7, DSP OPMODE width
INMODE_WIDTH, 5, DSP INMODE width
RPT_WIDTH, 4, repeat-count field width; an instruction runs rpt+1 elements
EXEC_LAT, 3, cycles per element window (must be >= 1)
I_WIDTH, RPT_WIDTH+2+ALUMODE_WIDTH+OPMODE_WIDTH+INMODE_WIDTH+3*ADDR_WIDTH, derived instruction width (37 at defaults)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
instr_i  in  I_WIDTH  instruction; fields MSB to LSB: rpt, inc, exec, alumode, opmode, inmode, w_addr, r1_addr, r0_addr
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  controller can accept an instruction
abort_i  in  1  synchronous abort of the running instruction
busy_o  out  1  an instruction is executing
done_o  out  1  one-cycle pulse when an instruction completes; not asserted on abort
bram1_web_o  out  1  BRAM1 write enable
bram1_reb_o  out  1  BRAM1 read enable
bram0_reb_o  out  1  BRAM0 read enable
alumode_o  out  ALUMODE_WIDTH  DSP ALUMODE
opmode_o  out  OPMODE_WIDTH  DSP OPMODE
inmode_o  out  INMODE_WIDTH  DSP INMODE
bram1_w_addr_o  out  ADDR_WIDTH  BRAM1 write address
bram1_r_addr_o  out  ADDR_WIDTH  BRAM1 read address
bram0_r_addr_o  out  ADDR_WIDTH  BRAM0 read address

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_ni. Asserting rst_ni=0 at any time, including mid-instruction, immediately sets state IDLE and clears all counters. All registered outputs go to 0: enables, modes, addresses, busy_o and done_o. No write occurs after reset asserts.
- States: IDLE, EXEC, DONE.
- instr_ready_o is combinational and equals (state==IDLE). It is therefore 1 immediately after reset.
- IDLE: a transfer happens on a clock edge where instr_valid_i=1 and instr_ready_o=1. At that edge the controller latches all fields, loads modes and base addresses onto the outputs, and clears the element counter e and cycle counter c. State goes to EXEC. The instruction is consumed at that edge.
- EXEC, enables and busy:
  - busy_o=1 throughout.
  - Each element occupies EXEC_LAT cycles, c = 0..EXEC_LAT-1.
  - bram0_reb_o and bram1_reb_o equal exec for the whole window.
  - bram1_web_o = exec only when c==EXEC_LAT-1, so it is high exactly one cycle per element.
- EXEC, modes and addresses: modes are constant for the instruction. Addresses equal base+e when inc=1 and stay at base when inc=0. Addresses wrap modulo 2^ADDR_WIDTH.
- EXEC, counters: at c==EXEC_LAT-1, if e<rpt, then e increments and c returns to 0. Otherwise state goes to DONE.
- exec=0 is a NOP: identical timing and done_o, but all enables stay 0.
- DONE: lasts one cycle. done_o=1, enables 0, busy_o=0, modes and addresses hold. Next state is IDLE. A new instruction can be accepted on the cycle after DONE.
- Latency: if the transfer edge is in cycle T, elements occupy cycles T+1 .. T+(rpt+1)*EXEC_LAT, and done_o is high in cycle T+(rpt+1)*EXEC_LAT+1.
- Abort: abort_i=1 in EXEC takes effect at the next edge. State goes to IDLE, enables clear, no done_o pulse. A write in that same cycle (c==EXEC_LAT-1) still completes, because web was already driven. abort_i is ignored in IDLE and DONE.
- instr_valid_i is ignored outside IDLE. A held-high valid is accepted again on the first IDLE cycle.
- EXEC_LAT=1: web and reb are high in the same cycle, one element per cycle.

Test Plan:
- Defaults; instr rpt=0 inc=0 exec=1, w=3, r1=4, r0=5 accepted at cycle T -> reb high T+1..T+3; web high only at T+3 with w_addr=3; done_o at T+4; ready at T+5.
- rpt=3 inc=1 exec=1, all bases=30 -> addresses 30,31,0,1, each held 3 cycles; 4 web pulses at wrap-correct addresses; done_o at T+13.
- rpt=2 inc=0 exec=0 -> no enables ever high; done_o at T+10; modes driven per instruction.
- instr_valid_i held high with 2 queued instructions -> second accepted exactly one cycle after the first's done_o; no overlap of enables.
- rpt=5 inc=1; abort_i at element 2, c=1 -> IDLE next edge, no further web, no done_o, ready=1.
- rst_ni low mid-element 1 -> all outputs 0 immediately; after release, a fresh instruction executes normally.
